// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-channel arbiter with a one-entry registered output stage.
// Selects one requesting producer per cycle, either by fixed priority
// (highest index wins) or by round-robin. The winning beat is captured into
// an output register that the single consumer drains under backpressure.
//
// Handshake: every interface uses strict valid/ready. A beat moves on a
// rising edge exactly when valid and ready are both high in that cycle. Valid
// never waits on ready. o_ready is a combinational function of i_valid,
// i_ready and internal state, and it never feeds back into any input.
module rr_arbiter_n #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int MODE   = 1,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_CH-1:0]        i_valid,
  input  logic [N_CH*DATA_W-1:0] i_data,
  output logic [N_CH-1:0]        o_ready,
  output logic                   o_valid,
  output logic [DATA_W-1:0]      o_data,
  output logic [CH_W-1:0]        o_ch,
  input  logic                   i_ready
);

  // The output register can take a new beat when it is empty or being drained.
  logic              load;
  logic              any_valid;
  logic [CH_W-1:0]   winner;
  logic [DATA_W-1:0] win_data;
  // Round-robin pointer: the channel granted most recently.
  logic [CH_W-1:0]   last;

  assign load      = ~o_valid | i_ready;
  assign any_valid = |i_valid;

  // Winner selection. Fixed priority picks the highest asserted index.
  // Round-robin picks the asserted channel with the smallest ascending
  // distance from last+1, wrapping at N_CH. The index does not need to be a
  // power of two.
  always_comb begin
    int d;
    int best_d;
    winner = '0;
    d      = 0;
    best_d = N_CH;
    if (MODE == 0) begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_valid[k]) winner = CH_W'(k);
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        d = k - int'(last) - 1;
        if (d < 0) d = d + N_CH;
        if (i_valid[k] && (d < best_d)) begin
          best_d = d;
          winner = CH_W'(k);
        end
      end
    end
  end

  // Data mux for the winning channel.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (winner == CH_W'(k)) win_data = i_data[k*DATA_W +: DATA_W];
    end
  end

  // Grant is one-hot or zero. It is only given when the output stage can load.
  always_comb begin
    o_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_ready[k] = load & i_valid[k] & (winner == CH_W'(k));
    end
  end

  // Output register. It loads the winner, or empties when nothing is
  // requested. Data and channel hold while empty.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
    end else if (load) begin
      if (any_valid) begin
        o_valid <= 1'b1;
        o_data  <= win_data;
        o_ch    <= winner;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  generate
    if (MODE == 1) begin : g_rr_ptr
      // The pointer advances only on an accepted input transfer. Reset
      // points it at the last channel, so the first search starts at 0.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          last <= CH_W'(N_CH - 1);
        end else if (load && any_valid) begin
          last <= winner;
        end
      end
    end else begin : g_fixed_ptr
      assign last = CH_W'(N_CH - 1);
    end
  endgenerate

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed bench for rr_arbiter_n. Three instances share the
// stimulus: fixed priority with 4 channels, round-robin with 4 channels, and
// round-robin with a single channel. A behavioural model tracks the expected
// output register contents for each instance. The outputs are compared every
// negative edge, and literal checks pin the scenarios.
module tb_rr_arbiter_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  i_valid = '0;
  logic [63:0] i_data  = '0;
  logic        i_ready = 1'b1;

  logic [3:0]  o_ready0, o_ready1;
  logic [0:0]  o_ready2;
  logic        o_valid0, o_valid1, o_valid2;
  logic [15:0] o_data0, o_data1, o_data2;
  logic [1:0]  o_ch0, o_ch1;
  logic [0:0]  o_ch2;

  rr_arbiter_n #(.N_CH(4), .DATA_W(16), .MODE(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready0), .o_valid(o_valid0), .o_data(o_data0), .o_ch(o_ch0),
    .i_ready(i_ready));

  rr_arbiter_n #(.N_CH(4), .DATA_W(16), .MODE(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready1), .o_valid(o_valid1), .o_data(o_data1), .o_ch(o_ch1),
    .i_ready(i_ready));

  rr_arbiter_n #(.N_CH(1), .DATA_W(16), .MODE(1)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid[0:0]), .i_data(i_data[15:0]),
    .o_ready(o_ready2), .o_valid(o_valid2), .o_data(o_data2), .o_ch(o_ch2),
    .i_ready(i_ready));

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int n_of(input int j);
    return (j == 2) ? 1 : 4;
  endfunction

  function automatic int mode_of(input int j);
    return (j == 0) ? 0 : 1;
  endfunction

  function automatic logic [3:0] vin(input int j);
    return (j == 2) ? (i_valid & 4'b0001) : i_valid;
  endfunction

  // Channel that must win given the request vector. Returns -1 when there is none.
  function automatic int pick(input int j, input logic [3:0] v, input int last);
    int n;
    int c;
    n = n_of(j);
    if (mode_of(j) == 0) begin
      for (int k = n - 1; k >= 0; k--) if (v[k]) return k;
      return -1;
    end
    for (int s = 1; s <= n; s++) begin
      c = (last + s) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic        m_valid[3];
  logic [15:0] m_data[3];
  int          m_ch[3];
  int          m_last[3];

  // Model state update: mirrors what the output register must hold.
  int mw;
  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        m_valid[j] <= 1'b0;
        m_data[j]  <= '0;
        m_ch[j]    <= 0;
        m_last[j]  <= n_of(j) - 1;
      end else if (!m_valid[j] || i_ready) begin
        mw = pick(j, vin(j), m_last[j]);
        if (mw >= 0) begin
          m_valid[j] <= 1'b1;
          m_data[j]  <= i_data[mw*16 +: 16];
          m_ch[j]    <= mw;
          if (mode_of(j) == 1) m_last[j] <= mw;
        end else begin
          m_valid[j] <= 1'b0;
        end
      end
    end
  end

  task automatic cmp_inst(input int j, input logic [3:0] rdy, input logic vld,
                          input logic [15:0] dat, input logic [31:0] ch);
    int w;
    logic [3:0] er;
    w  = pick(j, vin(j), m_last[j]);
    er = ((!m_valid[j] || i_ready) && (w >= 0)) ? (4'b0001 << w) : 4'b0000;
    chk($sformatf("model_ready%0d", j), {28'b0, rdy}, {28'b0, er});
    chk($sformatf("model_valid%0d", j), {31'b0, vld}, {31'b0, m_valid[j]});
    chk($sformatf("model_data%0d", j), {16'b0, dat}, {16'b0, m_data[j]});
    chk($sformatf("model_ch%0d", j), ch, 32'(m_ch[j]));
  endtask

  // Compare process: every negative edge, all instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, o_ready0, o_valid0, o_data0, {30'b0, o_ch0});
      cmp_inst(1, o_ready1, o_valid1, o_data1, {30'b0, o_ch1});
      cmp_inst(2, {3'b0, o_ready2}, o_valid2, o_data2, {31'b0, o_ch2});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    repeat (3) begin
      mid();
      chk("idle_valid", {31'b0, o_valid1}, 32'd0);
      chk("idle_data", {16'b0, o_data1}, 32'd0);
      chk("idle_ch", {30'b0, o_ch1}, 32'd0);
      chk("idle_ready", {28'b0, o_ready1}, 32'd0);
      tick();
    end

    // Fixed priority: channels 1 and 2 request, channel 2 always wins.
    i_data  = {16'h0000, 16'h2222, 16'h1111, 16'h0000};
    i_valid = 4'b0110;
    mid();
    chk("fp_ready", {28'b0, o_ready0}, 32'h4);
    chk("rr_first_ready", {28'b0, o_ready1}, 32'h2);
    tick();
    repeat (3) begin
      mid();
      chk("fp_valid", {31'b0, o_valid0}, 32'd1);
      chk("fp_data", {16'b0, o_data0}, 32'h2222);
      chk("fp_ch", {30'b0, o_ch0}, 32'd2);
      tick();
    end

    // Round-robin rotation from reset with all channels requesting.
    reset_pulse();
    i_valid = 4'b1111;
    i_data  = {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0};
    tick();
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("rr_seq_ch", {30'b0, o_ch1}, 32'(i % 4));
      chk("rr_seq_data", {16'b0, o_data1}, 32'h0000C0C0 + 32'h0101 * 32'(i % 4));
      chk("fp_all_ch", {30'b0, o_ch0}, 32'd3);
      tick();
    end

    // Backpressure: hold AAAA from ch3 while ch0 waits, then drain with no bubble.
    i_data  = {16'hAAAA, 16'h0000, 16'h0000, 16'h0B0B};
    i_valid = 4'b1000;
    i_ready = 1'b1;
    tick();
    i_valid = 4'b0001;
    i_ready = 1'b0;
    repeat (3) begin
      mid();
      chk("bp_ready", {28'b0, o_ready0}, 32'd0);
      chk("bp_valid", {31'b0, o_valid0}, 32'd1);
      chk("bp_data", {16'b0, o_data0}, 32'hAAAA);
      chk("bp_ch", {30'b0, o_ch0}, 32'd3);
      tick();
    end
    i_ready = 1'b1;
    mid();
    chk("bp_release_ready", {28'b0, o_ready0}, 32'h1);
    tick();
    mid();
    chk("bp_next_valid", {31'b0, o_valid0}, 32'd1);
    chk("bp_next_data", {16'b0, o_data0}, 32'h0B0B);
    chk("bp_next_ch", {30'b0, o_ch0}, 32'd0);
    tick();

    // Round-robin pointer holds across idle cycles.
    reset_pulse();
    i_data  = {16'h0000, 16'h5252, 16'h0000, 16'h5050};
    i_valid = 4'b0100;
    tick();
    i_valid = 4'b0000;
    tick();
    repeat (4) begin
      mid();
      chk("hold_idle_valid", {31'b0, o_valid1}, 32'd0);
      tick();
    end
    i_valid = 4'b0101;
    mid();
    chk("hold_ready", {28'b0, o_ready1}, 32'h1);
    tick();
    mid();
    chk("hold_ch", {30'b0, o_ch1}, 32'd0);
    chk("hold_data", {16'b0, o_data1}, 32'h5050);
    tick();

    // Reset in the middle of a stream.
    i_valid = 4'b1111;
    i_data  = {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0};
    tick();
    tick();
    mid();
    chk("pre_reset_valid", {31'b0, o_valid1}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("async_reset_valid1", {31'b0, o_valid1}, 32'd0);
    chk("async_reset_valid0", {31'b0, o_valid0}, 32'd0);
    tick();
    rst = 1'b0;
    mid();
    chk("post_reset_ready", {28'b0, o_ready1}, 32'h1);
    tick();
    mid();
    chk("post_reset_ch", {30'b0, o_ch1}, 32'd0);
    chk("post_reset_data", {16'b0, o_data1}, 32'hC0C0);
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-channel arbiter with per-channel valid/ready handshake and a registered output stage. It is the next generation of the team's 4-input combinational priority arbiter: channel count and data width are parameters, fixed-priority or round-robin mode is selectable, and the output carries a one-entry register with backpressure. It sits between N producers and one consumer on a shared 16-bit (default) data path.

## Interface
- `N_CH`, 4: number of input channels, ≥1.
- `DATA_W`, 16: data width per channel.
- `MODE`, 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `CH_W`, max(1, $clog2(N_CH)): width of the channel index (derived, not overridden).

Ports:
- `i_clk` input 1: clock, all logic rising-edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_valid` input N_CH: per-channel request; bit k is channel k.
- `i_data` input N_CH*DATA_W: channel k data at bits [k*DATA_W +: DATA_W].
- `o_ready` output N_CH: per-channel accept; a transfer on channel k occurs when i_valid[k] & o_ready[k].
- `o_valid` output 1: output register holds a beat.
- `o_data` output DATA_W: winning channel's data.
- `o_ch` output CH_W: index of the channel that produced o_data.
- `i_ready` input 1: consumer accept; output transfer when o_valid & i_ready.

## Operation
- load = ~o_valid | i_ready. Output register captures a new beat only when load = 1.
- Winner selection is combinational over i_valid:
  - MODE 0: highest-index asserted channel wins, identical to the predecessor's priority.
  - MODE 1: search starts at (last + 1) mod N_CH, ascending with wrap; first asserted channel wins. `last` is the internal pointer, CH_W bits.
- o_ready[k] = load & (winner == k) & i_valid[k]; at most one bit set (one-hot or zero).
- On a clock edge with load = 1:
  - any i_valid set: o_valid <= 1, o_data <= winner's data, o_ch <= winner; MODE 1: last <= winner.
  - no i_valid set: o_valid <= 0; o_data and o_ch hold.
- On a clock edge with load = 0 (o_valid & ~i_ready): o_valid, o_data, o_ch, last all hold; o_ready all 0.
- `last` updates only on an accepted input transfer; in MODE 0 it is unused.
- Producers hold i_valid and i_data stable until accepted; the block does not depend on this for correctness of its own state, but a withdrawn request is simply not granted.
- N_CH = 1: channel 0 always wins; o_ch constant 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by the environment): o_valid = 0, o_data = 0, o_ch = 0, last = N_CH-1 (first RR search starts at channel 0). o_ready follows combinationally: all bits equal to i_valid gated by winner, since load = 1.
- Latency: input accepted at edge t appears on o_data/o_valid after edge t (1 cycle).
- Throughput: one beat per cycle when i_ready held high.
- Combinational paths: i_valid → o_ready and i_ready → o_ready. No path from o_ready to any input is assumed.
- Simultaneous output drain and input accept in the same cycle (o_valid & i_ready & any i_valid): new beat replaces old with no bubble.
- Reset mid-operation: the held beat is discarded, pointer returns to N_CH-1; no transfer is reported for the reset cycle.
- RR fairness: with all N_CH channels continuously valid and i_ready = 1, each channel is granted exactly once in every N_CH consecutive grants.

## Test plan
- Reset then idle: i_valid = 0 → o_valid = 0, o_data = 0, o_ch = 0, o_ready = 0 every cycle.
- MODE 0, N_CH = 4: i_valid = 4'b0110, data2 = 16'h2222, data1 = 16'h1111, i_ready = 1 → o_ready = 4'b0100; next cycle o_valid = 1, o_data = 16'h2222, o_ch = 2; repeats each cycle (channel 1 starves).
- MODE 1, all four valid, i_ready = 1 from reset → o_ch sequence 0,1,2,3,0,1… with o_data matching each channel.
- Backpressure: o_valid = 1 holding 16'hAAAA from ch3, i_ready = 0 for 3 cycles with ch0 valid → o_ready = 0, o_data stays 16'hAAAA; on i_ready = 1, ch0 granted same cycle and o_data = ch0 data next cycle, no bubble.
- MODE 1 pointer hold: grant ch2, then i_valid = 0 for 5 cycles, then i_valid = 4'b0101 → ch0 wins (search starts at 3, wraps to 0); o_valid = 0 during idle cycles.
- Reset mid-stream: assert i_reset while o_valid = 1 → o_valid drops to 0 immediately (asynchronous); after release, MODE 1 with all valid grants ch0 first.
